// File: rtl/poly_adsr_mixer_pkg.sv
// poly_adsr_pkg: shared per-voice envelope state encoding
package poly_adsr_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;
endpackage

// File: rtl/poly_adsr_mixer_if.sv
// poly_adsr_mixer_if: frame input and mixed-sample output bundle
interface poly_adsr_mixer_if #(
   parameter int NUM_VOICES   = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ENV_WIDTH    = 16
);
   logic [NUM_VOICES*SAMPLE_WIDTH-1:0] sample_in;
   logic                               in_ready;
   logic [NUM_VOICES-1:0]              gate;
   logic [ENV_WIDTH-1:0]               attack_step;
   logic [ENV_WIDTH-1:0]               decay_step;
   logic [ENV_WIDTH-1:0]               sustain_level;
   logic [ENV_WIDTH-1:0]               release_step;
   logic [SAMPLE_WIDTH-1:0]            sample_out;
   logic                               out_valid;
   logic                               busy;
   logic [NUM_VOICES-1:0]              voice_active;
   logic                               overrun;

   modport master (
      output sample_in, in_ready, gate, attack_step, decay_step, sustain_level, release_step,
      input  sample_out, out_valid, busy, voice_active, overrun
   );
   modport slave (
      input  sample_in, in_ready, gate, attack_step, decay_step, sustain_level, release_step,
      output sample_out, out_valid, busy, voice_active, overrun
   );
endinterface

// File: rtl/poly_adsr_mixer_env_step.sv
// adsr_env_step: one-frame envelope/state update for a single voice
module adsr_env_step
   import poly_adsr_pkg::*;
#(
   parameter int ENV_WIDTH = 16
) (
   input  state_t               state,
   input  logic [ENV_WIDTH-1:0] env,
   input  logic                 gate_now,
   input  logic                 gate_prev,
   input  logic [ENV_WIDTH-1:0] attack_step,
   input  logic [ENV_WIDTH-1:0] decay_step,
   input  logic [ENV_WIDTH-1:0] sustain_level,
   input  logic [ENV_WIDTH-1:0] release_step,
   output state_t               next_state,
   output logic [ENV_WIDTH-1:0] next_env
);
   localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;
   state_t cur;
   logic [ENV_WIDTH:0] att_sum, dec_floor;
   assign att_sum   = {1'b0, env} + {1'b0, attack_step};
   assign dec_floor = {1'b0, sustain_level} + {1'b0, decay_step};
   // gate edges take effect first so the new phase's step lands in this same frame
   assign cur = (gate_now && !gate_prev) ? S_ATTACK :
                (!gate_now && state inside {S_ATTACK, S_DECAY, S_SUSTAIN}) ? S_RELEASE : state;
   always_comb begin
      next_state = cur;
      next_env   = '0;
      case (cur)
         S_ATTACK: begin
            next_env   = (attack_step == '0 || att_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : att_sum[ENV_WIDTH-1:0];
            next_state = (next_env == ENV_MAX) ? S_DECAY : S_ATTACK;
         end
         S_DECAY: begin
            next_env   = (decay_step == '0 || {1'b0, env} <= dec_floor) ? sustain_level : env - decay_step;
            next_state = (decay_step == '0 || {1'b0, env} <= dec_floor) ? S_SUSTAIN : S_DECAY;
         end
         S_SUSTAIN: next_env = sustain_level;
         S_RELEASE: begin
            next_env   = (release_step == '0 || env <= release_step) ? '0 : env - release_step;
            next_state = (release_step == '0 || env <= release_step) ? S_IDLE : S_RELEASE;
         end
         default: next_state = S_IDLE;
      endcase
   end
endmodule

// File: rtl/poly_adsr_mixer.sv
// poly_adsr_mixer: per-voice ADSR envelopes mixed into one saturated sample, one voice per cycle
module poly_adsr_mixer
   import poly_adsr_pkg::*;
#(
   parameter int NUM_VOICES   = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ENV_WIDTH    = 16
) (
   input logic clk,
   input logic reset,
   poly_adsr_mixer_if.slave bus
);
   localparam int VIDX_W = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1;
   localparam int ACC_W  = SAMPLE_WIDTH + VIDX_W + 1;
   localparam int PROD_W = SAMPLE_WIDTH + ENV_WIDTH + 1;
   localparam logic signed [ACC_W-1:0] SAT_HI = {{(VIDX_W+2){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   state_t                         st   [NUM_VOICES];
   logic [ENV_WIDTH-1:0]           env  [NUM_VOICES];
   logic signed [SAMPLE_WIDTH-1:0] smp  [NUM_VOICES];
   logic [NUM_VOICES-1:0]          glat, gprev;
   logic [ENV_WIDTH-1:0]           atk, dec, sus, rel;
   logic [VIDX_W-1:0]              v;
   logic signed [ACC_W-1:0]        acc, sum;
   logic signed [PROD_W-1:0]       prod;
   logic [SAMPLE_WIDTH-1:0]        sat;
   state_t                         nst;
   logic [ENV_WIDTH-1:0]           nenv;
   logic                           last;

   adsr_env_step #(.ENV_WIDTH(ENV_WIDTH)) u_step (
      .state(st[v]), .env(env[v]), .gate_now(glat[v]), .gate_prev(gprev[v]),
      .attack_step(atk), .decay_step(dec), .sustain_level(sus), .release_step(rel),
      .next_state(nst), .next_env(nenv)
   );

   // env is zero-extended so unity gain (ENV_MAX) stays positive in the signed product
   always_comb begin
      prod = PROD_W'(smp[v]) * PROD_W'($signed({1'b0, nenv}));
      sum  = acc + ACC_W'(prod >>> ENV_WIDTH);
      sat  = sum > SAT_HI ? SAMPLE_WIDTH'(SAT_HI) : sum < SAT_LO ? SAMPLE_WIDTH'(SAT_LO) : sum[SAMPLE_WIDTH-1:0];
      last = v == VIDX_W'(NUM_VOICES - 1);
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_act
      assign bus.voice_active[i] = st[i] != S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.busy       <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.overrun    <= 1'b0;
         bus.sample_out <= '0;
         gprev          <= '0;
         v              <= '0;
         acc            <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            st[i]  <= S_IDLE;
            env[i] <= '0;
         end
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.in_ready && bus.busy) bus.overrun <= 1'b1;
         if (bus.busy) begin
            st[v]    <= nst;
            env[v]   <= nenv;
            gprev[v] <= glat[v];
            acc      <= sum;
            v        <= v + 1'b1;
            if (last) begin
               bus.busy       <= 1'b0;
               bus.out_valid  <= 1'b1;
               bus.sample_out <= sat;
            end
         end else if (bus.in_ready) begin
            bus.busy <= 1'b1;
            v        <= '0;
            acc      <= '0;
            glat     <= bus.gate;
            atk      <= bus.attack_step;
            dec      <= bus.decay_step;
            sus      <= bus.sustain_level;
            rel      <= bus.release_step;
            for (int i = 0; i < NUM_VOICES; i++) smp[i] <= bus.sample_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         end
      end
   end
endmodule

// File: tb/tb_poly_adsr_mixer.sv
// tb_poly_adsr_mixer: scoreboard bench with an independent envelope/mix model
module tb_poly_adsr_mixer;
   localparam int IDLE = 0, ATK = 1, DEC = 2, SUS = 3, REL = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int nvec = 0, nerr = 0;
   logic [15:0] q[$];
   int menv[4], mst[4];
   bit mgp[4];

   poly_adsr_mixer_if #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .ENV_WIDTH(16)) bus ();
   poly_adsr_mixer #(.NUM_VOICES(4), .SAMPLE_WIDTH(16), .ENV_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (bus.out_valid) begin
         nvec++;
         if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_out_valid got sample_out=%0d with no frame pending", $signed(bus.sample_out));
         end else begin
            logic [15:0] e;
            e = q.pop_front();
            if (bus.sample_out !== e) begin
               nerr++;
               $display("FAIL mix sample_out=%0d expected=%0d", $signed(bus.sample_out), $signed(e));
            end
         end
      end
   end

   function automatic logic [63:0] rep(input logic [15:0] x);
      return {4{x}};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         menv[i] = 0;
         mst[i]  = IDLE;
         mgp[i]  = 1'b0;
      end
   endfunction

   function automatic int model_frame(input logic [63:0] s, input logic [3:0] g,
                                      input int atk, input int dec, input int sus, input int rel);
      int acc;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         int e, st;
         longint p, sc;
         e  = menv[i];
         st = mst[i];
         if (g[i] && !mgp[i]) st = ATK;
         else if (!g[i] && (st == ATK || st == DEC || st == SUS)) st = REL;
         mgp[i] = g[i];
         case (st)
            ATK: begin
               e = (atk == 0 || e + atk >= 65535) ? 65535 : e + atk;
               if (e == 65535) st = DEC;
            end
            DEC: begin
               e = (dec == 0) ? sus : (e - dec > sus ? e - dec : sus);
               if (e <= sus) begin
                  e  = sus;
                  st = SUS;
               end
            end
            SUS: e = sus;
            REL: begin
               e = (rel == 0 || e - rel < 0) ? 0 : e - rel;
               if (e == 0) st = IDLE;
            end
            default: e = 0;
         endcase
         menv[i] = e;
         mst[i]  = st;
         p  = longint'($signed(s[i*16 +: 16])) * longint'(e);
         sc = (p - (((p % 65536) + 65536) % 65536)) / 65536;
         acc += int'(sc);
      end
      return acc > 32767 ? 32767 : (acc < -32768 ? -32768 : acc);
   endfunction

   // called at a negedge; returns at the negedge one cycle after the strobe, inputs scrambled
   task automatic start_frame(input logic [63:0] s, input logic [3:0] g,
                              input logic [15:0] atk, input logic [15:0] dec,
                              input logic [15:0] sus, input logic [15:0] rel);
      bus.sample_in     = s;
      bus.gate          = g;
      bus.attack_step   = atk;
      bus.decay_step    = dec;
      bus.sustain_level = sus;
      bus.release_step  = rel;
      bus.in_ready      = 1'b1;
      q.push_back(16'(model_frame(s, g, int'(atk), int'(dec), int'(sus), int'(rel))));
      @(negedge clk);
      bus.in_ready      = 1'b0;
      bus.sample_in     = {$urandom, $urandom};
      bus.gate          = 4'($urandom);
      bus.attack_step   = 16'($urandom);
      bus.decay_step    = 16'($urandom);
      bus.sustain_level = 16'($urandom);
      bus.release_step  = 16'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      nvec++;
      if (lat != 5) begin
         nerr++;
         $display("FAIL latency got=%0d cycles expected=5", lat);
         if (!bus.out_valid && q.size() > 0) void'(q.pop_front());
      end
   endtask

   task automatic frame(input logic [63:0] s, input logic [3:0] g,
                        input logic [15:0] atk, input logic [15:0] dec,
                        input logic [15:0] sus, input logic [15:0] rel);
      int lat;
      start_frame(s, g, atk, dec, sus, rel);
      wait_out(lat);
   endtask

   task automatic check_voice0(input string tag, input int e, input int st);
      nvec++;
      if (dut.env[0] !== 16'(e) || int'(dut.st[0]) != st) begin
         nerr++;
         $display("FAIL %s env0=%h state0=%0d expected env0=%h state0=%0d", tag, dut.env[0], int'(dut.st[0]), 16'(e), st);
      end
   endtask

   task automatic test_reset();
      bus.in_ready = 1'b0;
      bus.sample_in = '0;
      bus.gate = '0;
      bus.attack_step = '0;
      bus.decay_step = '0;
      bus.sustain_level = '0;
      bus.release_step = '0;
      model_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      nvec++;
      if (bus.sample_out !== 16'd0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
          bus.overrun !== 1'b0 || bus.voice_active !== 4'b0) begin
         nerr++;
         $display("FAIL reset_state sample_out=%h out_valid=%b busy=%b overrun=%b active=%b expected all zero",
                  bus.sample_out, bus.out_valid, bus.busy, bus.overrun, bus.voice_active);
      end
      frame(rep(16'd1000), 4'b0000, 16'h4000, 16'h0, 16'h0, 16'h0);
      nvec++;
      if (bus.sample_out !== 16'd0 || bus.voice_active !== 4'b0) begin
         nerr++;
         $display("FAIL idle_frame sample_out=%0d active=%b expected 0 and 0000", $signed(bus.sample_out), bus.voice_active);
      end
      @(negedge clk);
      nvec++;
      if (bus.out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL pulse_width out_valid=%b one cycle after pulse expected 0", bus.out_valid);
      end
   endtask

   task automatic test_attack();
      int ee[4] = '{32'h4000, 32'h8000, 32'hC000, 32'hFFFF};
      int eo[4] = '{250, 500, 750, 999};
      for (int i = 0; i < 4; i++) begin
         frame(rep(16'd1000), 4'b0001, 16'h4000, 16'h0, 16'h0, 16'h0);
         check_voice0("attack_env", ee[i], i == 3 ? DEC : ATK);
         nvec++;
         if ($signed(bus.sample_out) != eo[i]) begin
            nerr++;
            $display("FAIL attack_out step%0d sample_out=%0d expected=%0d", i, $signed(bus.sample_out), eo[i]);
         end
      end
   endtask

   task automatic test_decay_release();
      int ee[4] = '{32'hEFFF, 32'hDFFF, 32'hCFFF, 32'hC000};
      for (int i = 0; i < 4; i++) begin
         frame(rep(16'd1000), 4'b0001, 16'h4000, 16'h1000, 16'hC000, 16'h0);
         check_voice0("decay_env", ee[i], i == 3 ? SUS : DEC);
      end
      frame(rep(16'd1000), 4'b0000, 16'h4000, 16'h1000, 16'hC000, 16'h0);
      check_voice0("release_instant", 0, IDLE);
      nvec++;
      if (bus.voice_active !== 4'b0000) begin
         nerr++;
         $display("FAIL release_active active=%b expected 0000", bus.voice_active);
      end
   endtask

   task automatic test_saturation();
      frame(rep(16'd32767), 4'b1111, 16'h0, 16'h0, 16'hFFFF, 16'h0);
      nvec++;
      if (bus.sample_out !== 16'h7FFF) begin
         nerr++;
         $display("FAIL sat_pos sample_out=%0d expected=32767", $signed(bus.sample_out));
      end
      frame(rep(16'h8000), 4'b1111, 16'h0, 16'h0, 16'hFFFF, 16'h0);
      nvec++;
      if (bus.sample_out !== 16'h8000 || bus.voice_active !== 4'b1111) begin
         nerr++;
         $display("FAIL sat_neg sample_out=%0d active=%b expected -32768 and 1111", $signed(bus.sample_out), bus.voice_active);
      end
   endtask

   task automatic test_overrun();
      int pulses, first;
      pulses = 0;
      first = 0;
      start_frame(rep(16'd500), 4'b1111, 16'h0, 16'h0, 16'h8000, 16'h0);
      for (int k = 2; k <= 15; k++) begin
         @(negedge clk);
         bus.in_ready = (k == 2);
         if (bus.out_valid) begin
            pulses++;
            if (first == 0) first = k;
         end
      end
      nvec++;
      if (pulses != 1 || first != 5 || bus.overrun !== 1'b1) begin
         nerr++;
         $display("FAIL overrun pulses=%0d first=%0d overrun=%b expected 1, 5, 1", pulses, first, bus.overrun);
      end
      start_frame(rep(16'd700), 4'b1111, 16'h0, 16'h0, 16'h8000, 16'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      model_reset();
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      nvec++;
      if (pulses != 0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0 || bus.voice_active !== 4'b0 ||
          dut.env[0] !== 16'h0 || dut.env[1] !== 16'h0 || dut.env[2] !== 16'h0 || dut.env[3] !== 16'h0) begin
         nerr++;
         $display("FAIL reset_abort pulses=%0d overrun=%b busy=%b active=%b env=%h/%h/%h/%h expected all zero",
                  pulses, bus.overrun, bus.busy, bus.voice_active, dut.env[0], dut.env[1], dut.env[2], dut.env[3]);
      end
   endtask

   task automatic test_retrigger();
      frame(rep(16'd2000), 4'b0001, 16'h0, 16'h0, 16'h8000, 16'h0);
      check_voice0("retrig_setup", 32'hFFFF, DEC);
      frame(rep(16'd2000), 4'b0000, 16'h0, 16'h0, 16'h8000, 16'h9FFF);
      check_voice0("retrig_release", 32'h6000, REL);
      frame(rep(16'd2000), 4'b0001, 16'h1000, 16'h0, 16'h8000, 16'h9FFF);
      check_voice0("retrig_attack", 32'h7000, ATK);
   endtask

   task automatic test_back_to_back();
      int lat;
      start_frame({$urandom, $urandom}, 4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         start_frame({$urandom, $urandom}, 4'($urandom), 16'($urandom_range(0, 16'h3000)),
                     16'($urandom_range(0, 16'h2000)), 16'($urandom), 16'($urandom_range(0, 16'h4000)));
         wait_out(lat);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain pending=%0d expected=0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_decay_release();
      test_saturation();
      test_overrun();
      test_retrigger();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/poly_adsr_mixer.md
Name: poly_adsr_mixer

Overview:
Polyphonic successor to the single-voice ADSR. It applies an independent attack/decay/sustain/release envelope to each of NUM_VOICES sample streams. It then mixes the scaled voices into one saturated codec sample. It sits between the music player voice outputs and the sample register feeding the codec and wave display, and runs once per in_ready frame. It uses one time-multiplexed multiplier.

Parameters:
NUM_VOICES, 4, number of voices (>=1); VIDX_W = max(1, clog2(NUM_VOICES)).
SAMPLE_WIDTH, 16, signed two's-complement sample width, in and out.
ENV_WIDTH, 16, unsigned envelope width; ENV_MAX = 2^ENV_WIDTH-1 (unity gain).

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high
sample_in  in  NUM_VOICES*SAMPLE_WIDTH  packed signed voice samples; voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
in_ready  in  1  one-cycle strobe: new frame available
gate  in  NUM_VOICES  note held, per voice
attack_step  in  ENV_WIDTH  envelope increment per frame; 0 = instantaneous
decay_step  in  ENV_WIDTH  envelope decrement per frame; 0 = instantaneous
sustain_level  in  ENV_WIDTH  sustain envelope value
release_step  in  ENV_WIDTH  envelope decrement per frame; 0 = instantaneous
sample_out  out  SAMPLE_WIDTH  mixed, saturated output
out_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  frame in progress
voice_active  out  NUM_VOICES  voice state != IDLE
overrun  out  1  sticky: in_ready arrived while busy

Behaviour:
- Reset: all envelopes 0, all states IDLE, previous-gate register 0, sample_out 0, out_valid 0, busy 0, overrun 0, voice_active 0. Reset during a frame aborts it: no out_valid and no envelope commit.
- Acceptance: in_ready is sampled in cycle T while busy=0. In T+1 the block latches sample_in, gate and all step/level inputs, and raises busy. Later input changes do not affect this frame.
- in_ready while busy=1: the strobe is dropped, overrun is set to 1, and stays 1 until reset.
- Voice processing: in cycles T+1..T+NUM_VOICES, voice index v = 0..NUM_VOICES-1 advances by one per cycle. Each cycle does the following for voice v:
  - updates the envelope and state;
  - forms scaled = (sample_v * env_v_new) >>> ENV_WIDTH, with env zero-extended, a signed product and an arithmetic shift (floor);
  - adds scaled into an accumulator of SAMPLE_WIDTH+VIDX_W+1 bits, cleared at the start of the frame.
- Output: in cycle T+NUM_VOICES+1, sample_out is the accumulator saturated to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]. out_valid=1 for exactly that cycle, and busy=0 in that cycle. sample_out holds until the next frame. Latency from in_ready to out_valid is NUM_VOICES+1 cycles. in_ready in the out_valid cycle is accepted.
- Mixing does not divide by the voice count; saturation is the only limiting.
- Gate edges use the latched gate versus the previous latched gate. Toggles between frames are invisible.
- Per-voice FSM (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE), one step per frame:
  - Rising gate from any state -> ATTACK, continuing from the current env (retrigger, no reset to 0). The first attack step is applied in the same frame.
  - Gate low while in ATTACK, DECAY or SUSTAIN -> RELEASE. The first release step is applied in the same frame.
  - ATTACK: env = min(env+attack_step, ENV_MAX), or ENV_MAX if the step is 0. If env reaches ENV_MAX -> DECAY.
  - DECAY: env = max(env-decay_step, sustain_level), or sustain_level if the step is 0. If env is at or below sustain_level -> SUSTAIN, clamped to sustain_level.
  - SUSTAIN: env tracks the current sustain_level every frame.
  - RELEASE: env = max(env-release_step, 0), or 0 if the step is 0. If env reaches 0 -> IDLE.
  - IDLE: env = 0.
- All step arithmetic uses ENV_WIDTH+1 bits so it never wraps.

Decomposition:
- Package poly_adsr_pkg: 3-bit state encodings S_IDLE=0, S_ATTACK=1, S_DECAY=2, S_SUSTAIN=3, S_RELEASE=4.
- Sub-module adsr_env_step: combinational function of (state, env, gate_now, gate_prev, steps, sustain) giving (next_state, next_env). It is instantiated once and time-multiplexed with the multiplier.
- Per-voice state and env are held in registers indexed by v.

Test Plan:
1. Reset, NUM_VOICES=4, all gates 0, every sample 1000, in_ready at cycle 0 -> out_valid at cycle 5 only, sample_out=0, voice_active=0000.
2. Voice0 gate=1, attack_step=0x4000, sample0=1000, one frame per test step -> env 0x4000, 0x8000, 0xC000, 0xFFFF; sample_out 250, 500, 750, 999; state DECAY after the fourth frame.
3. Continue with decay_step=0x1000, sustain=0xC000 -> env 0xEFFF, 0xDFFF, 0xCFFF, 0xC000 (SUSTAIN). Then gate=0 with release_step=0 -> env 0, IDLE, voice_active[0]=0.
4. All gates 1, attack_step=0, all samples 32767 -> sample_out saturates to 32767. All samples -32768 -> each voice gives -32768 and sample_out saturates to -32768.
5. Second in_ready at cycle 2 of a frame -> ignored, overrun=1, a single out_valid at cycle 5. Reset asserted at cycle 3 of a frame -> no out_valid, overrun=0, envelopes 0.
6. Voice in RELEASE at env 0x6000, gate re-rises, attack_step=0x1000 -> next frame env 0x7000, state ATTACK.
